// File: rtl/spi_slave_if.sv
// Signal bundle between an SPI mode-0 slave endpoint, its local logic and the serial pins.
// The slave modport is the endpoint's view; the master modport is the link/local-logic side.
interface spi_slave_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] slaveDataToSend;
   logic [DATA_WIDTH-1:0] slaveDataReceived;
   logic                  tx_load;
   logic                  rx_valid;
   logic                  busy;
   logic                  SCLK;
   logic                  CS;
   logic                  SDI;
   logic                  SDO;

   modport slave (
      input  slaveDataToSend, SCLK, CS, SDI,
      output slaveDataReceived, tx_load, rx_valid, busy, SDO
   );

   modport master (
      output slaveDataToSend, SCLK, CS, SDI,
      input  slaveDataReceived, tx_load, rx_valid, busy, SDO
   );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0, LSB-first slave that oversamples SCLK/CS/SDI on the local clock.
// Optional build macro SPI_SLAVE_SDO_TRISTATE_EN releases SDO (1'bz) while IDLE.
module spi_slave #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic     clk,
   input  logic     reset,
   spi_slave_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

   state_t                state_reg, state_next;
   logic [2:0]            sync_reg [SYNC_STAGES];   // {sclk, cs, sdi}
   logic                  sclk_d_reg, cs_d_reg, fall_pend_reg;
   logic [DATA_WIDTH-1:0] shift_tx_reg, shift_rx_reg, rx_data_reg;
   logic [CNT_W-1:0]      count_reg;
   logic                  sdo_reg, tx_load_reg, rx_valid_reg;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (reset) sync_reg[gi] <= '0;
               else       sync_reg[gi] <= {bus.SCLK, bus.CS, bus.SDI};
            end
         end else begin : g_rest
            always_ff @(posedge clk) begin
               if (reset) sync_reg[gi] <= '0;
               else       sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   logic sclk_s, cs_s, sdi_s;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   assign {sclk_s, cs_s, sdi_s} = sync_reg[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d_reg;
   assign sclk_fall = ~sclk_s & sclk_d_reg;
   assign cs_rise   = cs_s & ~cs_d_reg;
   assign cs_fall   = ~cs_s & cs_d_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_d_reg    <= 1'b0;
         cs_d_reg      <= 1'b0;
         fall_pend_reg <= 1'b0;
         state_reg     <= IDLE;
      end else begin
         sclk_d_reg    <= sclk_s;
         cs_d_reg      <= cs_s;
         fall_pend_reg <= sclk_fall;
         state_reg     <= state_next;
      end
   end

   // A deselect overrides everything, including an SCLK edge in the same cycle.
   always_comb begin
      state_next = state_reg;
      if (cs_rise) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    if (cs_fall) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   state_next = SHIFT;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shift_tx_reg <= '0;
         shift_rx_reg <= '0;
         rx_data_reg  <= '0;
         count_reg    <= '0;
         sdo_reg      <= 1'b0;
         tx_load_reg  <= 1'b0;
         rx_valid_reg <= 1'b0;
      end else begin
         tx_load_reg  <= 1'b0;
         rx_valid_reg <= 1'b0;
         // The word was already complete when the counter hit full, so commit it even on deselect.
         if (state_reg == SHIFT && count_reg == CNT_FULL) begin
            rx_data_reg  <= shift_rx_reg;
            rx_valid_reg <= 1'b1;
         end
         if (state_next == IDLE) begin
            count_reg <= '0;
            sdo_reg   <= 1'b0;
         end else begin
            case (state_reg)
               LOAD: begin
                  shift_tx_reg <= bus.slaveDataToSend;
                  sdo_reg      <= bus.slaveDataToSend[0];
                  tx_load_reg  <= 1'b1;
               end
               SHIFT: begin
                  if (count_reg == CNT_FULL) begin
                     count_reg <= '0;
                  end else if (sclk_rise) begin
                     shift_rx_reg <= {sdi_s, shift_rx_reg[DATA_WIDTH-1:1]};
                     count_reg    <= count_reg + CNT_W'(1);
                  end
                  // Falls act one cycle late so SDO moves SYNC_STAGES+2 cycles after the pin edge.
                  if (fall_pend_reg) begin
                     if (count_reg == '0) begin
                        shift_tx_reg <= bus.slaveDataToSend;
                        sdo_reg      <= bus.slaveDataToSend[0];
                        tx_load_reg  <= 1'b1;
                     end else begin
                        shift_tx_reg <= shift_tx_reg >> 1;
                        sdo_reg      <= shift_tx_reg[1];
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.tx_load           = tx_load_reg;
   assign bus.rx_valid          = rx_valid_reg;
   assign bus.slaveDataReceived = rx_data_reg;
   assign bus.busy              = (state_reg != IDLE);

`ifdef SPI_SLAVE_SDO_TRISTATE_EN
   assign bus.SDO = (state_reg == IDLE) ? 1'bz : sdo_reg;
`else
   assign bus.SDO = sdo_reg;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of single frames plus hand-written multi-cycle corner cases.
module tb_spi_slave;
   localparam int HALF     = 4;   // SCLK high/low time in clk cycles
   localparam int KEEP     = 0;   // leave CS low after the last bit
   localparam int END_FALL = 1;   // raise CS together with the last SCLK fall
   localparam int END_RISE = 2;   // raise CS together with the last SCLK rise

   typedef struct {
      logic [7:0] tx;
      logic [7:0] mosi;
      logic [7:0] exp_rx;
      logic [7:0] exp_miso;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [7:0] tx_word = 8'h00;
   logic b2b = 1'b0;
   int   b2b_base = 0;
   int   n_cmp = 0, n_bad = 0;
   int   n_txl = 0, n_rxv = 0;
   logic [7:0] rx_q [$];

   always #5 clk = ~clk;

   spi_slave_if #(.DATA_WIDTH(8)) bus ();

   spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.slaveDataToSend = (b2b && n_txl > b2b_base) ? 8'h98 : tx_word;

   always @(negedge clk) begin
      if (bus.tx_load === 1'b1) n_txl++;
      if (bus.rx_valid === 1'b1) begin
         n_rxv++;
         rx_q.push_back(bus.slaveDataReceived);
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic xfer(input logic [15:0] mosi, input int nrise, input int end_mode,
                       output logic [15:0] miso);
      miso = '0;
      @(negedge clk);
      bus.CS  = 1'b0;
      bus.SDI = mosi[0];
      repeat (6) @(negedge clk);
      for (int b = 0; b < nrise; b++) begin
         miso[b]  = bus.SDO;
         bus.SCLK = 1'b1;
         if (b == nrise - 1 && end_mode == END_RISE) bus.CS = 1'b1;
         repeat (HALF) @(negedge clk);
         bus.SCLK = 1'b0;
         bus.SDI  = (b + 1 < nrise) ? mosi[b+1] : 1'b0;
         if (b == nrise - 1 && end_mode == END_FALL) bus.CS = 1'b1;
         repeat (HALF) @(negedge clk);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic run_frame(input string name, input logic [7:0] tx, input logic [7:0] mosi,
                            input logic [7:0] exp_rx, input logic [7:0] exp_miso);
      logic [15:0] miso;
      int rxv0, txl0;
      tx_word = tx;
      rxv0 = n_rxv;
      txl0 = n_txl;
      rx_q.delete();
      xfer({8'h00, mosi}, 8, END_FALL, miso);
      check({name, " rx_valid count"}, 16'(n_rxv - rxv0), 16'd1);
      check({name, " received"}, {8'h00, bus.slaveDataReceived}, {8'h00, exp_rx});
      check({name, " master got"}, miso, {8'h00, exp_miso});
      check({name, " tx_load count"}, 16'(n_txl - txl0), 16'd1);
      check({name, " busy after"}, {15'h0, bus.busy}, 16'h0);
   endtask

   vec_t vecs [5];
   logic [15:0] miso;
   int rxv0, txl0;
   logic [7:0] held;

   initial begin
      vecs[0] = '{tx: 8'h7F, mosi: 8'h53, exp_rx: 8'h53, exp_miso: 8'h7F};
      vecs[1] = '{tx: 8'hA5, mosi: 8'h3C, exp_rx: 8'h3C, exp_miso: 8'hA5};
      vecs[2] = '{tx: 8'h00, mosi: 8'hFF, exp_rx: 8'hFF, exp_miso: 8'h00};
      vecs[3] = '{tx: 8'hFF, mosi: 8'h00, exp_rx: 8'h00, exp_miso: 8'hFF};
      vecs[4] = '{tx: 8'h81, mosi: 8'h18, exp_rx: 8'h18, exp_miso: 8'h81};

      bus.SCLK = 1'b0;
      bus.CS   = 1'b1;
      bus.SDI  = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      check("reset SDO",
`ifdef SPI_SLAVE_SDO_TRISTATE_EN
            {15'h0, bus.SDO}, {15'h0, 1'bz});
`else
            {15'h0, bus.SDO}, 16'h0);
`endif
      check("reset busy", {15'h0, bus.busy}, 16'h0);
      check("reset tx_load", {15'h0, bus.tx_load}, 16'h0);
      check("reset rx_valid", {15'h0, bus.rx_valid}, 16'h0);
      check("reset received", {8'h00, bus.slaveDataReceived}, 16'h0);

      // Deselected: SCLK activity must be ignored.
      repeat (6) @(negedge clk);
      rxv0 = n_rxv;
      txl0 = n_txl;
      for (int i = 0; i < 8; i++) begin
         bus.SCLK = ~bus.SCLK;
         bus.SDI  = ~bus.SDI;
         repeat (HALF) @(negedge clk);
      end
      check("idle busy", {15'h0, bus.busy}, 16'h0);
      check("idle SDO",
`ifdef SPI_SLAVE_SDO_TRISTATE_EN
            {15'h0, bus.SDO}, {15'h0, 1'bz});
`else
            {15'h0, bus.SDO}, 16'h0);
`endif
      check("idle tx_load count", 16'(n_txl - txl0), 16'd0);
      check("idle rx_valid count", 16'(n_rxv - rxv0), 16'd0);
      bus.SCLK = 1'b0;
      bus.SDI  = 1'b0;
      repeat (6) @(negedge clk);

      for (int i = 0; i < 5; i++)
         run_frame($sformatf("vec%0d", i), vecs[i].tx, vecs[i].mosi, vecs[i].exp_rx, vecs[i].exp_miso);

      // Back-to-back words under one select; upstream swaps the word after the first tx_load.
      tx_word  = 8'h83;
      b2b_base = n_txl;
      b2b      = 1'b1;
      rxv0 = n_rxv;
      rx_q.delete();
      xfer(16'h3C22, 16, END_FALL, miso);
      b2b = 1'b0;
      check("b2b rx_valid count", 16'(n_rxv - rxv0), 16'd2);
      check("b2b first word", (rx_q.size() > 0) ? {8'h00, rx_q[0]} : 16'hFFFF, 16'h0022);
      check("b2b second word", (rx_q.size() > 1) ? {8'h00, rx_q[1]} : 16'hFFFF, 16'h003C);
      check("b2b master got", miso, 16'h9883);
      check("b2b tx_load count", 16'(n_txl - b2b_base), 16'd2);

      // Abort after five bits: partial word discarded, then a clean frame.
      held = bus.slaveDataReceived;
      rxv0 = n_rxv;
      tx_word = 8'h11;
      xfer(16'h0025, 5, END_FALL, miso);
      check("abort rx_valid count", 16'(n_rxv - rxv0), 16'd0);
      check("abort received held", {8'h00, bus.slaveDataReceived}, {8'h00, held});
      check("abort busy", {15'h0, bus.busy}, 16'h0);
      run_frame("after abort", 8'h6E, 8'hC2, 8'hC2, 8'h6E);

      // Reset pulse at bit 3 of a frame.
      tx_word = 8'hF0;
      xfer(16'h00E7, 3, KEEP, miso);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset SDO",
`ifdef SPI_SLAVE_SDO_TRISTATE_EN
            {15'h0, bus.SDO}, {15'h0, 1'bz});
`else
            {15'h0, bus.SDO}, 16'h0);
`endif
      check("midreset busy", {15'h0, bus.busy}, 16'h0);
      check("midreset tx_load", {15'h0, bus.tx_load}, 16'h0);
      check("midreset rx_valid", {15'h0, bus.rx_valid}, 16'h0);
      check("midreset received", {8'h00, bus.slaveDataReceived}, 16'h0);
      bus.CS = 1'b1;
      repeat (8) @(negedge clk);
      run_frame("after reset", 8'h3C, 8'hA5, 8'hA5, 8'h3C);

      // CS rise arrives together with the 8th SCLK rise: deselect wins.
      held = bus.slaveDataReceived;
      rxv0 = n_rxv;
      xfer(16'h005A, 8, END_RISE, miso);
      check("coincide rx_valid count", 16'(n_rxv - rxv0), 16'd0);
      check("coincide received held", {8'h00, bus.slaveDataReceived}, {8'h00, held});
      check("coincide busy", {15'h0, bus.busy}, 16'h0);
      run_frame("after coincide", 8'hC3, 8'h96, 8'h96, 8'hC3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
